input_stream_ctrl: RTL
======================

Name: input_stream_ctrl

Overview:
- Sequences the test-vector input memory for the neural-network datapath.
- For each test sample, walks the feature index 0..FEATURES-1 and drives test_sel (1-based) and input_sel to the memory. It registers each 8-bit feature and streams it to the first layer over a valid/ready handshake.
- After the last feature, waits for the datapath's classification and reports it per test. Then advances to the next test until the programmed range is exhausted.

Parameters:
- FEATURES, 62, features per test sample; also the memory row stride.
- MAX_TESTS, 750, number of test samples stored in the memory.
- DATA_W, 8, feature width.
- CLASS_W, 4, classification result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run; ignored unless in IDLE.
- abort  in  1  synchronous; returns the block to IDLE from any state.
- first_test  in  32  first test index, 1-based, sampled on start.
- last_test  in  32  last test index, inclusive, sampled on start.
- test_sel  out  32  to memory: current test index.
- input_sel  out  32  to memory: current feature index.
- mem_result  in  DATA_W  combinational read data from memory.
- feat_data  out  DATA_W  registered feature to the datapath.
- feat_valid  out  1  feat_data is valid.
- feat_ready  in  1  datapath accepts the feature.
- feat_last  out  1  high with the final feature of a test.
- nn_done  in  1  one-cycle pulse; datapath classification complete.
- nn_class  in  CLASS_W  classification, valid when nn_done is high.
- res_valid  out  1  one-cycle pulse per finished test.
- res_test  out  32  test index of the reported result.
- res_class  out  CLASS_W  captured nn_class.
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse when the last test is reported.
- tests_done  out  32  count of tests reported in the current run.

Behaviour:
- Reset:
  - State is IDLE.
  - test_sel=1, input_sel=0, feat_data=0.
  - feat_valid, feat_last, res_valid, run_done and busy are 0.
  - res_test=0, res_class=0, tests_done=0.
- Range check on start:
  - If first_test is 0, first_test > last_test, or last_test > MAX_TESTS, the block does not start.
  - It pulses run_done for one cycle with tests_done=0 and stays in IDLE.
- States:
  - IDLE: on a valid start, latch last_test, set test_sel=first_test, input_sel=0, tests_done=0, go to LOAD.
  - LOAD (1 cycle, address stable): feat_data<=mem_result; feat_valid<=1; feat_last<=(input_sel==FEATURES-1); go to STREAM.
  - STREAM: feat_data, feat_valid and feat_last hold until feat_ready is high.
    - On handshake, drop feat_valid.
    - If feat_last is set: input_sel<=0, go to WAIT_NN.
    - Otherwise: input_sel<=input_sel+1, go to LOAD.
  - WAIT_NN: on nn_done:
    - Capture res_class and res_test=test_sel, pulse res_valid, tests_done+1.
    - If test_sel==last_test, pulse run_done and go to IDLE.
    - Otherwise test_sel+1, go to LOAD.
- Throughput: one feature per 2 cycles with feat_ready held high; a 62-feature test takes 124 cycles plus the datapath latency.
- nn_done outside WAIT_NN is ignored; no result is produced.
- Feature index and width rules:
  - input_sel never exceeds FEATURES-1.
  - The memory address (test_sel-1)*FEATURES+input_sel is formed in the memory, not here.
- abort:
  - Has priority over every other event in the same cycle.
  - Next state is IDLE; feat_valid, feat_last and busy go to 0; no res_valid or run_done pulse.
  - tests_done keeps its value.
- start during busy is ignored.
- start and abort in the same cycle in IDLE: abort wins and the block stays in IDLE.
- A reset mid-run returns all outputs to their reset values immediately.

Decomposition:
- Shared package nn_pkg: state encoding (IDLE, LOAD, STREAM, WAIT_NN), FEATURES, MAX_TESTS, DATA_W, CLASS_W.
- No sub-module needed. The counters and FSM live in one module; the memory stays external.

Test Plan:
- Reset then start, first_test=1, last_test=1, feat_ready=1, memory preloaded with 0x00..0x3D at row 1:
  - Expect 62 beats with feat_data=0x00..0x3D, each 2 cycles apart.
  - feat_last high only on 0x3D.
  - nn_done with nn_class=7 → res_valid, res_test=1, res_class=7, run_done, tests_done=1.
- Backpressure: feat_ready low for 5 cycles on beat 10 → feat_data and feat_valid stable throughout; input_sel=10 holds; no beat is lost or duplicated.
- Multi-test run, first_test=749, last_test=750 → two result pulses with res_test 749 and 750; test_sel never reaches 751; run_done once; tests_done=2.
- Invalid range, first_test=5, last_test=3 (and separately first_test=0) → no LOAD, busy stays 0, run_done pulse with tests_done=0.
- abort during STREAM at input_sel=30 → IDLE next cycle, feat_valid=0, no res_valid.
  - Subsequent start with first_test=2 restarts at input_sel=0, test_sel=2.
- Spurious nn_done in STREAM, and start while busy → both ignored; sequence and counts unchanged.
- Asserting rst mid-WAIT_NN → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the neural-network test-vector path.
package nn_pkg;

    localparam int FEATURES  = 62;
    localparam int MAX_TESTS = 750;
    localparam int DATA_W    = 8;
    localparam int CLASS_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_STREAM  = 2'd2,
        ST_WAIT_NN = 2'd3
    } state_t;

endpackage

// File: rtl/input_stream_ctrl.sv
// Walks the test-vector memory one feature at a time, streams each feature to the
// first layer over valid/ready and reports the classification of every test.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; range checked on start
// ST_LOAD    | memory address stable for one cycle; feature registered
// ST_STREAM  | feature presented, held until feat_ready
// ST_WAIT_NN | all features sent, waiting for nn_done
module input_stream_ctrl
    import nn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        first_test,
    input  logic [31:0]        last_test,
    output logic [31:0]        test_sel,
    output logic [31:0]        input_sel,
    input  logic [DATA_W-1:0]  mem_result,
    output logic [DATA_W-1:0]  feat_data,
    output logic               feat_valid,
    input  logic               feat_ready,
    output logic               feat_last,
    input  logic               nn_done,
    input  logic [CLASS_W-1:0] nn_class,
    output logic               res_valid,
    output logic [31:0]        res_test,
    output logic [CLASS_W-1:0] res_class,
    output logic               busy,
    output logic               run_done,
    output logic [31:0]        tests_done
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_test_sel;
    logic [31:0]         r_input_sel;
    logic [31:0]         r_last_test;
    logic [DATA_W-1:0]   r_feat_data;
    logic                r_feat_valid;
    logic                r_feat_last;
    logic                r_res_valid;
    logic [31:0]         r_res_test;
    logic [CLASS_W-1:0]  r_res_class;
    logic                r_run_done;
    logic [31:0]         r_tests_done;
    logic                w_range_ok;
    logic                w_final_test;

    assign w_range_ok   = (first_test != 32'd0) && (first_test <= last_test) &&
                          (last_test <= 32'(MAX_TESTS));
    assign w_final_test = (r_test_sel == r_last_test);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start && w_range_ok) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_STREAM;
            ST_STREAM:  if (feat_ready) w_state_nxt = r_feat_last ? ST_WAIT_NN : ST_LOAD;
            ST_WAIT_NN: if (nn_done) w_state_nxt = w_final_test ? ST_IDLE : ST_LOAD;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_test_sel   <= 32'd1;
            r_input_sel  <= 32'd0;
            r_last_test  <= 32'd0;
            r_feat_data  <= '0;
            r_feat_valid <= 1'b0;
            r_feat_last  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_test   <= 32'd0;
            r_res_class  <= '0;
            r_run_done   <= 1'b0;
            r_tests_done <= 32'd0;
        end else begin
            r_res_valid <= 1'b0;
            r_run_done  <= 1'b0;
            if (abort) begin
                r_feat_valid <= 1'b0;
                r_feat_last  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_tests_done <= 32'd0;
                            if (w_range_ok) begin
                                r_last_test <= last_test;
                                r_test_sel  <= first_test;
                                r_input_sel <= 32'd0;
                            end else begin
                                r_run_done  <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        r_feat_data  <= mem_result;
                        r_feat_valid <= 1'b1;
                        r_feat_last  <= (r_input_sel == 32'(FEATURES - 1));
                    end
                    ST_STREAM: begin
                        if (feat_ready) begin
                            r_feat_valid <= 1'b0;
                            r_feat_last  <= 1'b0;
                            r_input_sel  <= r_feat_last ? 32'd0 : r_input_sel + 32'd1;
                        end
                    end
                    ST_WAIT_NN: begin
                        if (nn_done) begin
                            r_res_class  <= nn_class;
                            r_res_test   <= r_test_sel;
                            r_res_valid  <= 1'b1;
                            r_tests_done <= r_tests_done + 32'd1;
                            if (w_final_test) r_run_done <= 1'b1;
                            else              r_test_sel <= r_test_sel + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign test_sel   = r_test_sel;
    assign input_sel  = r_input_sel;
    assign feat_data  = r_feat_data;
    assign feat_valid = r_feat_valid;
    assign feat_last  = r_feat_last;
    assign res_valid  = r_res_valid;
    assign res_test   = r_res_test;
    assign res_class  = r_res_class;
    assign run_done   = r_run_done;
    assign tests_done = r_tests_done;
    assign busy       = (r_state != ST_IDLE);

endmodule
